// File: rtl/program_loader.sv
`timescale 1ns/1ps
// Program-load feeder: takes a framed byte stream, assembles 16-bit instruction words, drives the
// program-memory write port, checks the XOR checksum and releases start_execution after load_done.
module program_loader #(
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [15:0]           prog_data_out,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic                  prog_write_enable,
  input  logic                  sys_load_done,
  output logic                  start_execution,
  output logic                  busy,
  output logic [1:0]            error_code
);

  localparam int MAX_WORDS = 1 << ADDR_WIDTH;
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_CSUM, S_WAIT_DONE, S_RUN, S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              csum_q, csum_d;
  logic [7:0]              hi_q, hi_d;
  logic [7:0]              remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [TW-1:0]           idle_q, idle_d;
  logic [15:0]             prog_data_q, prog_data_d;
  logic [ADDR_WIDTH-1:0]   prog_addr_q, prog_addr_d;
  logic                    prog_we_q, prog_we_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic [1:0]              error_code_q, error_code_d;
  logic                    accept;

  // Valid/ready: a byte transfers on a rising edge where byte_valid && byte_ready; the source
  // holds byte_in stable until then, and byte_valid has no effect while byte_ready is low.
  assign byte_ready = !reset && ((state_q == S_IDLE) || (state_q == S_HI) ||
                                 (state_q == S_LO)   || (state_q == S_CSUM));
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d      = state_q;
    csum_d       = csum_q;
    hi_d         = hi_q;
    remaining_d  = remaining_q;
    addr_d       = addr_q;
    idle_d       = idle_q;
    prog_data_d  = prog_data_q;
    prog_addr_d  = prog_addr_q;
    prog_we_d    = 1'b0;
    error_code_d = error_code_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          csum_d      = byte_in;
          remaining_d = byte_in;
          if (byte_in == 8'd0 || int'(byte_in) > MAX_WORDS) begin
            state_d      = S_ERROR;
            error_code_d = 2'd1;
          end else begin
            addr_d  = '0;
            idle_d  = '0;
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = byte_in;
          csum_d  = csum_q ^ byte_in;
          idle_d  = '0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          csum_d      = csum_q ^ byte_in;
          prog_we_d   = 1'b1;
          prog_addr_d = addr_q;
          prog_data_d = {hi_q, byte_in};
          idle_d      = '0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        remaining_d = remaining_q - 8'd1;
        addr_d      = addr_q + ADDR_WIDTH'(1);
        idle_d      = '0;
        state_d     = (remaining_q == 8'd1) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (accept) begin
          idle_d = '0;
          if (byte_in == csum_q) begin
            state_d = S_WAIT_DONE;
          end else begin
            state_d      = S_ERROR;
            error_code_d = 2'd2;
          end
        end
      end
      S_WAIT_DONE: begin
        if (sys_load_done) state_d = S_RUN;
      end
      default: ;
    endcase

    // Inter-byte watchdog; an accept on the expiry edge has already moved the state on.
    if ((state_q == S_HI || state_q == S_LO || state_q == S_CSUM) && !accept) begin
      if (idle_q == TIMEOUT_LAST) begin
        state_d      = S_ERROR;
        error_code_d = 2'd3;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end

    busy_d  = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_WRITE) ||
              (state_d == S_CSUM) || (state_d == S_WAIT_DONE);
    start_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      csum_q       <= '0;
      hi_q         <= '0;
      remaining_q  <= '0;
      addr_q       <= '0;
      idle_q       <= '0;
      prog_data_q  <= '0;
      prog_addr_q  <= '0;
      prog_we_q    <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      error_code_q <= '0;
    end else begin
      state_q      <= state_d;
      csum_q       <= csum_d;
      hi_q         <= hi_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      idle_q       <= idle_d;
      prog_data_q  <= prog_data_d;
      prog_addr_q  <= prog_addr_d;
      prog_we_q    <= prog_we_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      error_code_q <= error_code_d;
    end
  end

  assign prog_data_out     = prog_data_q;
  assign prog_addr         = prog_addr_q;
  assign prog_write_enable = prog_we_q;
  assign start_execution   = start_q;
  assign busy              = busy_q;
  assign error_code        = error_code_q;

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// Directed bench for program_loader: framed loads, checksum/count/timeout errors, mid-frame reset
// and the full-depth frame, with a write scoreboard fed by an expected queue.
module tb_program_loader;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [15:0]   prog_data_out;
  logic [AW-1:0] prog_addr;
  logic          prog_write_enable;
  logic          sys_load_done = 1'b0;
  logic          start_execution;
  logic          busy;
  logic [1:0]    error_code;

  int tests_run = 0;
  int tests_failed = 0;
  logic [AW+15:0] exp_q[$];
  logic prev_we = 1'b0;

  program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .prog_data_out(prog_data_out), .prog_addr(prog_addr),
    .prog_write_enable(prog_write_enable), .sys_load_done(sys_load_done),
    .start_execution(start_execution), .busy(busy), .error_code(error_code)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_outs"}, 32'({prog_write_enable, prog_addr, prog_data_out, start_execution,
                               busy, error_code}), 32'd0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // driver
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    assert (n < 50) else begin
      tests_failed++;
      $error("FAIL send_accept: byte %0h not taken after %0d cycles, required under 50", b, n);
    end
    if (n < 50) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  // write scoreboard
  always @(negedge clk) begin
    if (prog_write_enable) begin
      logic [AW+15:0] e;
      check("strobe_single_cycle", 32'(prev_we), 32'd0);
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL unexpected_write: addr %0h data %0h, required no write", prog_addr, prog_data_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr_data", 32'({prog_addr, prog_data_out}), 32'(e));
      end
    end
    prev_we = prog_write_enable;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hi, lo, cs;

    // 1: good three-word frame
    do_reset("rst1");
    sys_load_done = 1'b1;
    exp_q.push_back({5'd0, 16'h8101});
    exp_q.push_back({5'd1, 16'h8901});
    exp_q.push_back({5'd2, 16'h0A20});
    send_byte(8'h03, 0);
    send_byte(8'h81, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("t1_we_after_lo", 32'(prog_write_enable), 32'd1);
    check("t1_addr0", 32'(prog_addr), 32'd0);
    check("t1_data0", 32'(prog_data_out), 32'h8101);
    check("t1_ready_in_write", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("t1_we_drop", 32'(prog_write_enable), 32'd0);
    check("t1_hold", 32'({prog_addr, prog_data_out}), 32'({5'd0, 16'h8101}));
    send_byte(8'h89, 0);
    send_byte(8'h01, 0);
    send_byte(8'h0A, 1);
    send_byte(8'h20, 0);
    send_byte(8'h21, 0);
    @(negedge clk);
    check("t1_wait_busy", 32'({busy, start_execution}), 32'b10);
    @(negedge clk);
    check("t1_run", 32'({start_execution, busy, error_code}), 32'b1000);
    check("t1_ready_run", 32'(byte_ready), 32'd0);
    check("t1_all_writes", 32'(exp_q.size()), 32'd0);

    // 2: same frame, bad checksum
    do_reset("rst2");
    exp_q.push_back({5'd0, 16'h8101});
    exp_q.push_back({5'd1, 16'h8901});
    exp_q.push_back({5'd2, 16'h0A20});
    send_byte(8'h03, 0);
    send_byte(8'h81, 0);
    send_byte(8'h01, 0);
    send_byte(8'h89, 2);
    send_byte(8'h01, 0);
    send_byte(8'h0A, 0);
    send_byte(8'h20, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    check("t2_err_csum", 32'(error_code), 32'd2);
    repeat (5) @(negedge clk);
    check("t2_stuck", 32'({byte_ready, start_execution, busy, error_code}), 32'b00010);
    check("t2_all_writes", 32'(exp_q.size()), 32'd0);

    // 3: bad counts
    do_reset("rst3a");
    send_byte(8'h00, 0);
    @(negedge clk);
    check("t3_count0", 32'({byte_ready, busy, error_code}), 32'b0001);
    do_reset("rst3b");
    send_byte(8'h21, 0);
    @(negedge clk);
    check("t3_count33", 32'({byte_ready, busy, error_code}), 32'b0001);
    repeat (3) @(negedge clk);

    // 4: timeout exactly 16 cycles after the last accept
    do_reset("rst4");
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    repeat (16) @(negedge clk);
    check("t4_no_err_15", 32'({busy, error_code}), 32'b100);
    @(negedge clk);
    check("t4_timeout", 32'({busy, error_code}), 32'b011);
    check("t4_ready", 32'(byte_ready), 32'd0);

    // 5: bytes just inside / on the timeout boundary
    do_reset("rst5");
    sys_load_done = 1'b1;
    exp_q.push_back({5'd0, 16'hABCD});
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 14);
    @(negedge clk);
    check("t5_no_err_lo", 32'({prog_write_enable, error_code}), 32'b100);
    send_byte(8'h67, 15);
    @(negedge clk);
    check("t5_accept_wins", 32'({busy, error_code}), 32'b100);
    @(negedge clk);
    check("t5_run", 32'({start_execution, error_code}), 32'b100);

    // 6: random gaps, reset after second write, then reload without load_done
    do_reset("rst6");
    sys_load_done = 1'b0;
    exp_q.push_back({5'd0, 16'h1234});
    exp_q.push_back({5'd1, 16'h5678});
    send_byte(8'h04, $urandom_range(0, 5));
    send_byte(8'h12, $urandom_range(0, 5));
    send_byte(8'h34, $urandom_range(0, 5));
    send_byte(8'h56, $urandom_range(0, 5));
    send_byte(8'h78, $urandom_range(0, 5));
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_reset_outs", 32'({prog_write_enable, prog_addr, prog_data_out, start_execution,
                                busy, error_code, byte_ready}), 32'd0);
    check("t6_two_writes", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    exp_q.push_back({5'd0, 16'h1234});
    exp_q.push_back({5'd1, 16'h5678});
    exp_q.push_back({5'd2, 16'h9ABC});
    exp_q.push_back({5'd3, 16'hDEF0});
    send_byte(8'h04, $urandom_range(0, 5));
    send_byte(8'h12, $urandom_range(0, 5));
    send_byte(8'h34, $urandom_range(0, 5));
    send_byte(8'h56, $urandom_range(0, 5));
    send_byte(8'h78, $urandom_range(0, 5));
    send_byte(8'h9A, $urandom_range(0, 5));
    send_byte(8'hBC, $urandom_range(0, 5));
    send_byte(8'hDE, $urandom_range(0, 5));
    send_byte(8'hF0, $urandom_range(0, 5));
    send_byte(8'h04, $urandom_range(0, 5));
    repeat (10) @(negedge clk);
    check("t6_wait_done", 32'({busy, start_execution, byte_ready, error_code}), 32'b10000);
    check("t6_all_writes", 32'(exp_q.size()), 32'd0);
    sys_load_done = 1'b1;
    @(negedge clk);
    check("t6_run", 32'({start_execution, busy}), 32'b10);

    // 7: full-depth frame, last write at the top address
    do_reset("rst7");
    cs = 8'h20;
    send_byte(8'h20, 0);
    for (int i = 0; i < 32; i++) begin
      hi = 8'(i * 3 + 1);
      lo = 8'hF0 ^ 8'(i);
      cs = cs ^ hi ^ lo;
      exp_q.push_back({5'(i), hi, lo});
      send_byte(hi, 0);
      send_byte(lo, 0);
    end
    send_byte(cs, 0);
    @(negedge clk);
    @(negedge clk);
    check("t7_run", 32'({start_execution, error_code}), 32'b100);
    check("t7_last", 32'({prog_addr, prog_data_out}), 32'({5'd31, 16'h5EEF}));
    check("t7_all_writes", 32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
